// File: rtl/spi_rx.sv
// -----------------------------------------------------------------------------
// spi_rx - receive-side (target) deserializer for the 3-wire SPI write link.
//
// Samples the asynchronous SEN/SCLK/SDATA pins in the clock domain. It then
// shifts in one frame, MSB first: ADDR_BITS of address followed by DATA_BITS
// of data. Each good frame is presented on a valid/ack holding register.
//
// Optional feature:
//   Define SPI_RX_ADDR_FILTER_EN to deliver only frames whose address
//   satisfies (addr & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK).
//   A good frame that fails the filter is silently discarded.
//
// Ports:
//   clock      in   system clock
//   reset_n    in   synchronous, active-low reset
//   SEN        in   serial enable, active low (asynchronous)
//   SCLK       in   serial clock, idle low (asynchronous)
//   SDATA      in   serial data, sampled on SCLK rising edge (asynchronous)
//   rx_ack     in   downstream consumes the held frame
//   rx_valid   out  held frame available
//   rx_addr    out  held address
//   rx_data    out  held data
//   busy       out  frame in progress
//   frame_err  out  one-cycle pulse: frame ended with a wrong bit count
//   overrun    out  one-cycle pulse: good frame dropped, holding register full
// -----------------------------------------------------------------------------
module spi_rx #(
  parameter int                   ADDR_BITS  = 8,
  parameter int                   DATA_BITS  = 16,
  parameter logic [ADDR_BITS-1:0] ADDR_MATCH = '0,
  parameter logic [ADDR_BITS-1:0] ADDR_MASK  = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 SEN,
  input  logic                 SCLK,
  input  logic                 SDATA,
  input  logic                 rx_ack,
  output logic                 rx_valid,
  output logic [ADDR_BITS-1:0] rx_addr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronizer lanes: bit 0 = SEN, bit 1 = SCLK, bit 2 = SDATA.
  // SEN resets high (deasserted); the others reset low.
  localparam logic [2:0] SYNC_RST = 3'b001;

`ifdef SPI_RX_ADDR_FILTER_EN
  localparam logic FILTER_ON = 1'b1;
`else
  localparam logic FILTER_ON = 1'b0;
`endif

  // When the filter is disabled the effective mask is all zeros. The compare
  // then folds to a constant true.
  localparam logic [ADDR_BITS-1:0] EFF_MASK = ADDR_MASK & {ADDR_BITS{FILTER_ON}};

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [2:0] pin_vec;
  logic [2:0] sync_vec;

  assign pin_vec = {SDATA, SCLK, SEN};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        meta_reg <= SYNC_RST[gi];
        sync_reg <= SYNC_RST[gi];
      end else begin
        meta_reg <= pin_vec[gi];
        sync_reg <= meta_reg;
      end
    end

    assign sync_vec[gi] = sync_reg;
  end

  logic sen_s;
  logic sclk_s;
  logic sdata_s;

  assign sen_s   = sync_vec[0];
  assign sclk_s  = sync_vec[1];
  assign sdata_s = sync_vec[2];

  logic sen_d_reg;
  logic sclk_d_reg;

  // The synchronizers reset to SEN = 1, so just after reset sen_s and sen_d
  // can report a "high" that was never seen on the pin. This small fill
  // register marks the point where both reflect real pin samples. Until then,
  // WAIT will not treat SEN as idle. This prevents a frame that was already
  // running across reset from being picked up part-way through.
  logic [2:0] prime_reg;
  logic       primed;

  assign primed = prime_reg[2];

  logic sclk_rise;
  logic sen_fall;
  logic sen_rise;

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sen_fall  = ~sen_s & sen_d_reg;
  assign sen_rise  = sen_s & ~sen_d_reg;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_t                  state_reg;
  state_t                  state_next;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [FRAME_BITS-1:0]   shift_next;
  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;

  // Frame verdict, registered one cycle after sen_rise. The holding register
  // acts on the verdict in the following cycle.
  logic                    good_pend_reg;
  logic                    good_pend_next;
  logic                    bad_pend_reg;
  logic                    bad_pend_next;

  // Holding register and status pulses.
  logic                    rx_valid_reg;
  logic                    rx_valid_next;
  logic [ADDR_BITS-1:0]    rx_addr_reg;
  logic [ADDR_BITS-1:0]    rx_addr_next;
  logic [DATA_BITS-1:0]    rx_data_reg;
  logic [DATA_BITS-1:0]    rx_data_next;
  logic                    frame_err_reg;
  logic                    frame_err_next;
  logic                    overrun_reg;
  logic                    overrun_next;

  logic [ADDR_BITS-1:0]    frame_addr;
  logic [DATA_BITS-1:0]    frame_data;
  logic                    addr_ok;
  logic                    deliver;

  // The shift register still holds the finished frame in the verdict cycle.
  // It can only be cleared by a later sen_fall, and that cannot occur before
  // the holding register has been loaded.
  assign frame_addr = shift_reg[FRAME_BITS-1 -: ADDR_BITS];
  assign frame_data = shift_reg[DATA_BITS-1:0];
  assign addr_ok    = ((frame_addr & EFF_MASK) == (ADDR_MATCH & EFF_MASK));
  assign deliver    = good_pend_reg & addr_ok;

  // Next-state logic: FSM, shifter and bit counter.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    count_next     = count_reg;
    good_pend_next = 1'b0;
    bad_pend_next  = 1'b0;

    case (state_reg)
      ST_WAIT: begin
        if (primed && sen_s) begin
          state_next = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (sen_fall) begin
          shift_next = '0;
          count_next = '0;
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (sen_rise) begin
          state_next = ST_IDLE;
          if (count_reg == CNT_FULL) begin
            good_pend_next = 1'b1;
          end else begin
            bad_pend_next = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], sdata_s};
          // Saturate one past full length, so that long frames stay
          // distinguishable from good frames.
          if (count_reg != CNT_SAT) begin
            count_next = count_reg + CNT_ONE;
          end
        end
      end

      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

  // Next-state logic: holding register.
  always_comb begin
    rx_valid_next  = rx_valid_reg;
    rx_addr_next   = rx_addr_reg;
    rx_data_next   = rx_data_reg;
    frame_err_next = bad_pend_reg;
    overrun_next   = 1'b0;

    if (deliver) begin
      // An ack arriving in the same cycle as a new frame frees the slot.
      if (!rx_valid_reg || rx_ack) begin
        rx_valid_next = 1'b1;
        rx_addr_next  = frame_addr;
        rx_data_next  = frame_data;
      end else begin
        overrun_next  = 1'b1;
      end
    end else if (rx_valid_reg && rx_ack) begin
      rx_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sen_d_reg     <= 1'b1;
      sclk_d_reg    <= 1'b0;
      prime_reg     <= '0;
      state_reg     <= ST_WAIT;
      shift_reg     <= '0;
      count_reg     <= '0;
      good_pend_reg <= 1'b0;
      bad_pend_reg  <= 1'b0;
      rx_valid_reg  <= 1'b0;
      rx_addr_reg   <= '0;
      rx_data_reg   <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sen_d_reg     <= sen_s;
      sclk_d_reg    <= sclk_s;
      prime_reg     <= {prime_reg[1:0], 1'b1};
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      count_reg     <= count_next;
      good_pend_reg <= good_pend_next;
      bad_pend_reg  <= bad_pend_next;
      rx_valid_reg  <= rx_valid_next;
      rx_addr_reg   <= rx_addr_next;
      rx_data_reg   <= rx_data_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign rx_valid  = rx_valid_reg;
  assign rx_addr   = rx_addr_reg;
  assign rx_data   = rx_data_reg;
  assign busy      = (state_reg == ST_SHIFT);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_rx - directed, table-driven bench for spi_rx.
// The SCLK half period is 4 clock cycles, which gives a clock/SCLK ratio of 8.
// All pin changes are made on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_rx;

  logic        clock;
  logic        reset_n;
  logic        SEN;
  logic        SCLK;
  logic        SDATA;
  logic        rx_ack;
  logic        rx_valid;
  logic [7:0]  rx_addr;
  logic [15:0] rx_data;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

`ifdef SPI_RX_ADDR_FILTER_EN
  localparam logic [7:0] SEQ_ADDR_A = 8'h43;
  localparam logic [7:0] SEQ_ADDR_B = 8'h4B;
`else
  localparam logic [7:0] SEQ_ADDR_A = 8'h33;
  localparam logic [7:0] SEQ_ADDR_B = 8'h77;
`endif

  spi_rx #(
    .ADDR_BITS  (8),
    .DATA_BITS  (16),
    .ADDR_MATCH (8'h40),
    .ADDR_MASK  (8'hF0)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .SEN       (SEN),
    .SCLK      (SCLK),
    .SDATA     (SDATA),
    .rx_ack    (rx_ack),
    .rx_valid  (rx_valid),
    .rx_addr   (rx_addr),
    .rx_data   (rx_data),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters, sampled mid-cycle, so that each one-cycle pulse counts once.
  always @(negedge clock) begin
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sen_drop();
    repeat (4) @(negedge clock);
    SEN = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Sends word[nbits-1:0], MSB first, as one bit per SCLK period.
  task automatic shift_bits(input int nbits, input logic [31:0] word);
    for (int i = nbits - 1; i >= 0; i--) begin
      SDATA = word[i];
      repeat (4) @(negedge clock);
      SCLK = 1'b1;
      repeat (4) @(negedge clock);
      SCLK = 1'b0;
    end
  endtask

  task automatic sen_raise();
    repeat (4) @(negedge clock);
    SDATA = 1'b0;
    SEN   = 1'b1;
  endtask

  typedef struct {
    int          nbits;
    logic [31:0] word;
    bit          ack_done;
    bit          ack_after;
    bit          exp_valid;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
    bit          exp_ferr;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[8];
  int   n_vec;
  bit   model_valid;
  int   fe0;
  int   ov0;

  initial begin
`ifdef SPI_RX_ADDR_FILTER_EN
    n_vec   = 3;
    vecs[0] = '{24, 32'h004C1234, 1'b0, 1'b0, 1'b1, 8'h4C, 16'h1234, 1'b0, 1'b0};
    vecs[1] = '{24, 32'h005C5678, 1'b0, 1'b1, 1'b1, 8'h4C, 16'h1234, 1'b0, 1'b0};
    vecs[2] = '{23, 32'h00012345, 1'b0, 1'b0, 1'b0, 8'h4C, 16'h1234, 1'b1, 1'b0};
`else
    n_vec   = 8;
    vecs[0] = '{24, 32'h005AC3E1, 1'b0, 1'b1, 1'b1, 8'h5A, 16'hC3E1, 1'b0, 1'b0};
    vecs[1] = '{23, 32'h007FFFFF, 1'b0, 1'b0, 1'b0, 8'h5A, 16'hC3E1, 1'b1, 1'b0};
    vecs[2] = '{25, 32'h01ABCDEF, 1'b0, 1'b0, 1'b0, 8'h5A, 16'hC3E1, 1'b1, 1'b0};
    vecs[3] = '{24, 32'h00011111, 1'b0, 1'b0, 1'b1, 8'h01, 16'h1111, 1'b0, 1'b0};
    vecs[4] = '{24, 32'h00022222, 1'b0, 1'b1, 1'b1, 8'h01, 16'h1111, 1'b0, 1'b1};
    vecs[5] = '{24, 32'h00011111, 1'b0, 1'b0, 1'b1, 8'h01, 16'h1111, 1'b0, 1'b0};
    vecs[6] = '{24, 32'h00022222, 1'b1, 1'b1, 1'b1, 8'h02, 16'h2222, 1'b0, 1'b0};
    vecs[7] = '{0,  32'h00000000, 1'b0, 1'b0, 1'b0, 8'h02, 16'h2222, 1'b1, 1'b0};
`endif

    SEN     = 1'b1;
    SCLK    = 1'b0;
    SDATA   = 1'b0;
    rx_ack  = 1'b0;
    reset_n = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_rx_valid",  32'(rx_valid),  32'h0);
    check("reset_rx_addr",   32'(rx_addr),   32'h0);
    check("reset_rx_data",   32'(rx_data),   32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    model_valid = 1'b0;

    // ---------------- table-driven frames ----------------
    for (int i = 0; i < n_vec; i++) begin
      sen_drop();
      shift_bits(vecs[i].nbits, vecs[i].word);
      sen_raise();
      // The SEN rise is first sampled at edge k; the result is visible after k+3.
      repeat (3) @(posedge clock);
      #1;
      check("pre_update_valid", 32'(rx_valid), 32'(model_valid));
      if (vecs[i].ack_done) rx_ack = 1'b1;
      @(posedge clock);
      #1;
      rx_ack = 1'b0;
      check("valid",     32'(rx_valid),  32'(vecs[i].exp_valid));
      check("addr",      32'(rx_addr),   32'(vecs[i].exp_addr));
      check("data",      32'(rx_data),   32'(vecs[i].exp_data));
      check("frame_err", 32'(frame_err), 32'(vecs[i].exp_ferr));
      check("overrun",   32'(overrun),   32'(vecs[i].exp_ovr));
      check("busy_idle", 32'(busy),      32'h0);
      @(posedge clock);
      #1;
      check("pulse_width", 32'({frame_err, overrun}), 32'h0);
      if (vecs[i].ack_after) begin
        rx_ack = 1'b1;
        @(posedge clock);
        #1;
        rx_ack = 1'b0;
        check("ack_clears_valid", 32'(rx_valid), 32'h0);
        model_valid = 1'b0;
      end else begin
        model_valid = vecs[i].exp_valid;
      end
      $display("vector %0d: bits=%0d word=%06h valid=%0b addr=%02h data=%04h", i,
               vecs[i].nbits, vecs[i].word[23:0], rx_valid, rx_addr, rx_data);
    end

    // ---------------- SEN held low through reset release ----------------
    @(negedge clock);
    SEN     = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    fe0 = ferr_cnt;
    shift_bits(10, 32'h000002A5);
    sen_raise();
    repeat (10) @(negedge clock);
    check("sen_low_reset_no_ferr",  32'(ferr_cnt), 32'(fe0));
    check("sen_low_reset_no_valid", 32'(rx_valid), 32'h0);
    sen_drop();
    shift_bits(24, {8'h00, SEQ_ADDR_A, 16'hABCD});
    sen_raise();
    repeat (6) @(negedge clock);
    check("sen_low_reset_valid", 32'(rx_valid), 32'h1);
    check("sen_low_reset_addr",  32'(rx_addr),  32'(SEQ_ADDR_A));
    check("sen_low_reset_data",  32'(rx_data),  32'h0000ABCD);
    check("sen_low_reset_ferr",  32'(ferr_cnt), 32'(fe0));
    $display("sequence sen-low-reset: valid=%0b addr=%02h data=%04h", rx_valid, rx_addr, rx_data);
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;

    // ---------------- reset after the 12th SCLK edge ----------------
    sen_drop();
    shift_bits(12, 32'h00000F0F);
    repeat (4) @(negedge clock);
    check("midframe_busy_before", 32'(busy), 32'h1);
    fe0 = ferr_cnt;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midframe_busy_after_reset", 32'(busy), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    shift_bits(12, 32'h00000ABC);
    sen_raise();
    repeat (10) @(negedge clock);
    check("midframe_no_ferr",  32'(ferr_cnt), 32'(fe0));
    check("midframe_no_valid", 32'(rx_valid), 32'h0);
    ov0 = ovr_cnt;
    sen_drop();
    shift_bits(24, {8'h00, SEQ_ADDR_B, 16'h5A5A});
    sen_raise();
    repeat (6) @(negedge clock);
    check("midframe_next_valid", 32'(rx_valid), 32'h1);
    check("midframe_next_addr",  32'(rx_addr),  32'(SEQ_ADDR_B));
    check("midframe_next_data",  32'(rx_data),  32'h00005A5A);
    check("midframe_next_ferr",  32'(ferr_cnt), 32'(fe0));
    check("midframe_next_ovr",   32'(ovr_cnt),  32'(ov0));
    $display("sequence midframe-reset: valid=%0b addr=%02h data=%04h", rx_valid, rx_addr, rx_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
